// File: rtl/pe_row_ctrl.sv
// pe_row_ctrl: sequencer for one 16-PE convolution row.
// Loads the weight bank, streams pixel beats, tags products, signals pass end.
module pe_row_ctrl #(
  parameter int ROW_W  = 16,
  parameter int PE_LAT = 2,
  parameter int CNT_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               w_rd_req,
  output logic [3:0]         w_rd_addr,
  input  logic               w_rd_valid,
  input  logic [7:0]         w_rd_data,
  output logic [8*ROW_W-1:0] weight,
  output logic [1:0]         mode_out,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic               pe_en,
  output logic               prod_valid,
  output logic [CNT_W-1:0]   prod_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_W = 4'(ROW_W - 1);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               req_q, req_d;
  logic [3:0]         addr_q, addr_d;
  logic [8*ROW_W-1:0] wbank_q, wbank_d;
  logic [1:0]         mode_q, mode_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [PE_LAT-1:0]  vld_q, vld_d;
  logic [CNT_W-1:0]   idx_q [PE_LAT];
  logic [CNT_W-1:0]   idx_d [PE_LAT];

  assign pe_en = pix_valid & rdy_q;

  // next-state and next-output computation for the pass sequencer
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    wbank_d = wbank_q;
    mode_d  = mode_q;
    rdy_d   = rdy_q;
    len_d   = len_q;
    beat_d  = beat_q;
    vld_d[0] = pe_en;
    idx_d[0] = beat_q;
    for (int i = 1; i < PE_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_mode == 2'd3) begin
            err_d = 1'b1;
          end else if (cfg_len == '0) begin
            mode_d  = cfg_mode;
            state_d = S_DONE;
          end else begin
            mode_d  = cfg_mode;
            len_d   = cfg_len;
            addr_d  = 4'd0;
            req_d   = 1'b1;
            state_d = S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        if (req_q && w_rd_valid) begin
          wbank_d[8*addr_q +: 8] = w_rd_data;
          if (addr_q == LAST_W) begin
            req_d   = 1'b0;
            rdy_d   = 1'b1;
            beat_d  = '0;
            state_d = S_STREAM;
          end else begin
            addr_d = addr_q + 4'd1;
          end
        end
      end
      S_STREAM: begin
        if (pe_en) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == len_q - CNT_W'(1)) begin
            rdy_d   = 1'b0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (vld_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= 4'd0;
      wbank_q <= '0;
      mode_q  <= 2'd0;
      rdy_q   <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < PE_LAT; i++) idx_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wbank_q <= wbank_d;
      mode_q  <= mode_d;
      rdy_q   <= rdy_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
      for (int i = 0; i < PE_LAT; i++) idx_q[i] <= idx_d[i];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign w_rd_req   = req_q;
  assign w_rd_addr  = addr_q;
  assign weight     = wbank_q;
  assign mode_out   = mode_q;
  assign pix_ready  = rdy_q;
  assign prod_valid = vld_q[PE_LAT-1];
  assign prod_idx   = idx_q[PE_LAT-1];

endmodule

// File: tb/tb_pe_row_ctrl.sv
// tb_pe_row_ctrl: directed and randomized passes against a
// cycle-offset reference model of the row sequencer.
module tb_pe_row_ctrl;
  localparam int ROW_W  = 16;
  localparam int PE_LAT = 2;
  localparam int CNT_W  = 10;
  localparam int NMAX   = 512;

  typedef logic [8*ROW_W-1:0] wide_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_len;
  logic               busy, done, err;
  logic               w_rd_req;
  logic [3:0]         w_rd_addr;
  logic               w_rd_valid;
  logic [7:0]         w_rd_data;
  logic [8*ROW_W-1:0] weight;
  logic [1:0]         mode_out;
  logic               pix_valid, pix_ready, pe_en;
  logic               prod_valid;
  logic [CNT_W-1:0]   prod_idx;

  pe_row_ctrl #(.ROW_W(ROW_W), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .busy(busy), .done(done), .err(err),
    .w_rd_req(w_rd_req), .w_rd_addr(w_rd_addr),
    .w_rd_valid(w_rd_valid), .w_rd_data(w_rd_data),
    .weight(weight), .mode_out(mode_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pe_en(pe_en),
    .prod_valid(prod_valid), .prod_idx(prod_idx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [1:0] prev_mode;
  wide_t      prev_bank;

  bit         wv [NMAX];
  bit         pv [NMAX];
  logic [7:0] wd [NMAX];
  bit         e_req [NMAX];
  bit         e_rdy [NMAX];
  bit         e_pe [NMAX];
  bit         e_pv [NMAX];
  bit         e_busy [NMAX];
  bit         e_done [NMAX];
  int         e_idx [NMAX];
  int         e_addr [NMAX];

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy", wide_t'(busy), '0);
    chk("rst_done", wide_t'(done), '0);
    chk("rst_err", wide_t'(err), '0);
    chk("rst_req", wide_t'(w_rd_req), '0);
    chk("rst_addr", wide_t'(w_rd_addr), '0);
    chk("rst_weight", weight, '0);
    chk("rst_mode", wide_t'(mode_out), '0);
    chk("rst_ready", wide_t'(pix_ready), '0);
    chk("rst_pe_en", wide_t'(pe_en), '0);
    chk("rst_prod_valid", wide_t'(prod_valid), '0);
    chk("rst_prod_idx", wide_t'(prod_idx), '0);
  endtask

  // wmode: 0 always valid, 1 every other cycle, 2 random
  // pmode: 0 always valid, 1 fixed gap pattern, 2 random
  task automatic run_pass(input logic [1:0] mode, input int len,
                          input int wmode, input int pmode,
                          input bit spam, input int abort_beat);
    int    nbytes, nb, cl, cb, ab_c, n, k;
    logic [7:0] pat;
    wide_t ebank;
    pat   = 8'b1101_1001;
    ebank = prev_bank;
    for (int o = 0; o < NMAX; o++) begin
      wv[o] = 1'($urandom_range(0, 1));
      wd[o] = 8'($urandom_range(0, 255));
      pv[o] = 1'($urandom_range(0, 1));
      e_req[o] = 0; e_rdy[o] = 0; e_pe[o] = 0; e_pv[o] = 0;
      e_busy[o] = 0; e_done[o] = 0; e_idx[o] = 0; e_addr[o] = 0;
    end
    nbytes = 0;
    cl = -1;
    for (int o = 1; o < NMAX && cl < 0; o++) begin
      e_req[o]  = 1;
      e_addr[o] = nbytes;
      if (wmode == 0) wv[o] = 1;
      else if (wmode == 1) wv[o] = (o % 2 == 0);
      else if (o > 200) wv[o] = 1;
      if (wmode == 0) wd[o] = 8'(nbytes + 1);
      if (wv[o]) begin
        ebank[8*nbytes +: 8] = wd[o];
        nbytes++;
        if (nbytes == ROW_W) cl = o;
      end
    end
    nb = 0;
    cb = -1;
    ab_c = -1;
    for (int o = cl + 1; o < NMAX && cb < 0; o++) begin
      k = o - cl - 1;
      e_rdy[o] = 1;
      if (pmode == 0) pv[o] = 1;
      else if (pmode == 1) pv[o] = (k < 8) ? pat[k] : 1'b1;
      else if (o > 400) pv[o] = 1;
      if (pv[o]) begin
        e_pe[o] = 1;
        e_pv[o + PE_LAT]  = 1;
        e_idx[o + PE_LAT] = nb;
        nb++;
        if (nb == abort_beat) ab_c = o;
        if (nb == len) cb = o;
      end
    end
    for (int o = 1; o <= cb + PE_LAT + 1; o++) e_busy[o] = 1;
    e_done[cb + PE_LAT + 2] = 1;
    n = cb + PE_LAT + 4;
    for (int o = 0; o < n; o++) begin
      @(posedge clk);
      #1;
      start    = (o == 0) || (spam && o >= 1 && o <= cb + PE_LAT + 1);
      cfg_mode = (o == 0) ? mode : 2'($urandom_range(0, 3));
      cfg_len  = (o == 0) ? CNT_W'(len) : CNT_W'($urandom_range(0, 30));
      w_rd_valid = wv[o];
      w_rd_data  = wd[o];
      pix_valid  = pv[o];
      rst = (abort_beat > 0) && (o == ab_c + 1);
      if (abort_beat > 0 && o == ab_c + 2) pix_valid = 1'b1;
      @(negedge clk);
      if (abort_beat > 0 && o == ab_c + 2) begin
        chk_zero();
        prev_mode = 2'd0;
        prev_bank = '0;
        start = 1'b0;
        return;
      end
      chk("busy", wide_t'(busy), wide_t'(e_busy[o]));
      chk("done", wide_t'(done), wide_t'(e_done[o]));
      chk("err", wide_t'(err), '0);
      chk("w_rd_req", wide_t'(w_rd_req), wide_t'(e_req[o]));
      if (e_req[o]) chk("w_rd_addr", wide_t'(w_rd_addr), wide_t'(e_addr[o]));
      chk("pix_ready", wide_t'(pix_ready), wide_t'(e_rdy[o]));
      chk("pe_en", wide_t'(pe_en), wide_t'(e_pe[o]));
      chk("prod_valid", wide_t'(prod_valid), wide_t'(e_pv[o]));
      if (e_pv[o]) chk("prod_idx", wide_t'(prod_idx), wide_t'(e_idx[o]));
      chk("mode_out", wide_t'(mode_out),
          wide_t'((o == 0) ? prev_mode : mode));
      if (o == 0) chk("weight_hold", weight, prev_bank);
    end
    start = 1'b0;
    chk("weight_bank", weight, ebank);
    chk("weight0", wide_t'(weight[7:0]), wide_t'(ebank[7:0]));
    prev_mode = mode;
    prev_bank = ebank;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mode = 2'd0; cfg_len = '0;
    w_rd_valid = 1'b0; w_rd_data = 8'd0; pix_valid = 1'b0;
    prev_mode = 2'd0;
    prev_bank = '0;
    repeat (3) @(posedge clk);
    #1;
    pix_valid = 1'b1;
    w_rd_valid = 1'b1;
    @(negedge clk);
    chk_zero();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    w_rd_valid = 1'b0;

    // bytes 0x01..0x10, everything always valid, len 4
    run_pass(2'd0, 4, 0, 0, 1'b0, 0);
    // weight buffer answers every other cycle
    run_pass(2'd1, 3, 1, 0, 1'b0, 0);
    // pixel gaps 1,0,0,1,1,0,1,1
    run_pass(2'd2, 5, 0, 1, 1'b0, 0);

    // reserved mode rejected
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = 2'd3; cfg_len = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", wide_t'(err), 1);
    chk("err_busy", wide_t'(busy), '0);
    chk("err_req", wide_t'(w_rd_req), '0);
    chk("err_mode", wide_t'(mode_out), wide_t'(prev_mode));
    @(negedge clk);
    chk("err_one_cycle", wide_t'(err), '0);
    chk("err_busy2", wide_t'(busy), '0);

    // zero-length pass
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = 2'd2; cfg_len = '0; pix_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("z_busy1", wide_t'(busy), 1);
    chk("z_done1", wide_t'(done), '0);
    chk("z_mode", wide_t'(mode_out), 2);
    chk("z_req1", wide_t'(w_rd_req), '0);
    @(negedge clk);
    chk("z_done2", wide_t'(done), 1);
    chk("z_busy2", wide_t'(busy), '0);
    chk("z_req2", wide_t'(w_rd_req), '0);
    chk("z_pe_en", wide_t'(pe_en), '0);
    chk("z_prod", wide_t'(prod_valid), '0);
    @(negedge clk);
    chk("z_done3", wide_t'(done), '0);
    prev_mode = 2'd2;

    // start spammed while busy, then a fresh pass in mode 1
    run_pass(2'd0, 6, 0, 2, 1'b1, 0);
    run_pass(2'd1, 3, 2, 2, 1'b0, 0);

    // randomized passes
    for (int r = 0; r < 4; r++) begin
      run_pass(2'($urandom_range(0, 2)), int'($urandom_range(1, 20)),
               2, 2, 1'($urandom_range(0, 1)), 0);
    end

    // reset during stream after 2 of 8 beats
    run_pass(2'd2, 8, 0, 0, 1'b0, 2);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", wide_t'(busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_row_ctrl.md
Name: pe_row_ctrl

Overview:
Sequencer for one 16-PE convolution row: mode-capable PEs 0-2 plus plain PEs 3-15.
- On a start command it latches the pass configuration.
- It loads 16 weight bytes from the weight buffer into its weight register bank, then streams cfg_len pixel vectors into the row under a valid/ready handshake.
- It flags product validity after the PE pipeline latency and pulses done after the last product.
- It sits between the DLA top controller and the PE row.

Parameters:
ROW_W, 16, number of PEs and weight bytes per row
PE_LAT, 2, cycles from an accepted pixel beat to its product at the row output
CNT_W, 10, width of pass length and beat counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  pass request; sampled only in IDLE
cfg_mode  input  2  PE mode for the pass; 0-2 legal, 3 reserved
cfg_len  input  CNT_W  number of pixel vectors in the pass
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at pass end
err  output  1  one-cycle pulse when start is rejected
w_rd_req  output  1  weight buffer read request
w_rd_addr  output  4  weight index 0..15
w_rd_valid  input  1  read data valid
w_rd_data  input  8  weight byte
weight  output  8*ROW_W  weight bank; byte i at bits [8i+7:8i], to the PE row weight inputs
mode_out  output  2  mode to the PE row; constant for the whole pass
pix_valid  input  1  upstream pixel vector valid
pix_ready  output  1  controller accepts a pixel vector
pe_en  output  1  pixel vector is presented to the row this cycle (= pix_valid & pix_ready)
prod_valid  output  1  row products are valid this cycle
prod_idx  output  CNT_W  index of the beat whose product is valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, and applies in every state, including mid-pass.
- Reset values: state=IDLE. All outputs 0: busy, done, err, w_rd_req, w_rd_addr, weight bank, mode_out, pix_ready, pe_en, prod_valid, prod_idx. The latency shift register is cleared.
- IDLE:
  - start=1 with cfg_mode=3: err=1 next cycle, stay IDLE, nothing latched.
  - start=1 with cfg_len=0: latch mode, go directly to DONE. No weight reads, no beats.
  - Otherwise: latch mode_out<=cfg_mode and len<=cfg_len, set w_rd_addr=0, go to LOAD_W.
- LOAD_W:
  - w_rd_req=1, w_rd_addr held until the cycle w_rd_valid=1.
  - On each valid cycle: weight[addr]<=w_rd_data, addr increments.
  - w_rd_valid while w_rd_req=0 is ignored.
  - After byte 15 is written: w_rd_req=0, go to STREAM next cycle. Minimum 16 cycles in LOAD_W.
- STREAM:
  - pix_ready=1. A beat occurs when pix_valid=1: pe_en=1 combinationally and beat_cnt increments.
  - The beat with beat_cnt==len-1 is the last; the next state is DRAIN and pix_ready drops in DRAIN.
  - pix_valid gaps stall the pass with no timeout.
- Product tagging:
  - prod_valid equals pe_en delayed exactly PE_LAT cycles.
  - prod_idx equals the beat index delayed PE_LAT cycles, counting 0..len-1.
- DRAIN: wait until the delay line is empty (PE_LAT cycles after the last beat), then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in DONE and low in IDLE.
- Static outputs during a pass: weight and mode_out are stable from the end of LOAD_W until the next pass starts. They hold their values in IDLE; there is no clear on done.
- start while busy is ignored (no err, no queueing).
- Counters never wrap within a pass, because len is at most 2^CNT_W-1.
- Throughput: back-to-back beats every cycle when pix_valid stays high.
- Total latency (pix_valid constantly high, w_rd_valid constantly high): start -> done = 1 + 16 + len + PE_LAT + 1 cycles.

Test Plan:
1. Reset then start, cfg_mode=0, cfg_len=4, weight bytes 0x01..0x10, valid always high -> weight[0]=0x01 and weight[15]=0x10; pe_en high 4 consecutive cycles; prod_valid on cycles 2 later with prod_idx 0,1,2,3; done 24 cycles after start.
2. Weight buffer returns w_rd_valid every other cycle -> w_rd_addr holds while valid is low; LOAD_W lasts 32 cycles; bank contents correct.
3. cfg_len=5 with pix_valid pattern 1,0,0,1,1,0,1,1 -> exactly 5 pe_en pulses; prod_valid pattern identical shifted by 2; done once.
4. Start with cfg_mode=3 -> err pulse, busy stays 0, no w_rd_req. Start with cfg_len=0, cfg_mode=2 -> mode_out=2, done pulse 2 cycles later, no reads, no beats.
5. start asserted repeatedly during STREAM -> ignored; after done, a new start with cfg_mode=1 -> mode_out switches to 1 only at the new start.
6. rst asserted in STREAM after 2 of 8 beats -> next cycle state IDLE, all outputs 0 including the weight bank; pending prod_valid is suppressed.
